// File: rtl/hex_frame_arbiter.sv
// hex_frame_arbiter
// Owns the 48-segment active-low HEX display bus. Three requesters share it:
// the game engine writes single segments and can clear its frame, the
// message overlay takes over the whole display for a number of move ticks,
// and the apple blinker toggles one segment on every move tick.
//
// Ports:
//   clockInp, resetN          clock and synchronous active-low reset
//   tick                      one-cycle move tick
//   seg_wr_req/idx/val/ack    game segment write handshake (req held until ack)
//   clr_req                   one-cycle pulse, clears the game frame to dark
//   msg_req/frame/ack         message handshake, frame sampled on acceptance
//   msg_done                  one-cycle pulse when a message hold expires
//   busy                      high while a message owns the display
//   blink_en, blink_idx       apple blink control
//   HEX                       registered display output (1 = segment dark)
module hex_frame_arbiter #(
  parameter int SEG_W      = 48,
  parameter int HOLD_TICKS = 20
) (
  input  logic             clockInp,
  input  logic             resetN,
  input  logic             tick,
  input  logic             seg_wr_req,
  input  logic [5:0]       seg_wr_idx,
  input  logic             seg_wr_val,
  output logic             seg_wr_ack,
  input  logic             clr_req,
  input  logic             msg_req,
  input  logic [SEG_W-1:0] msg_frame,
  output logic             msg_ack,
  output logic             msg_done,
  output logic             busy,
  input  logic             blink_en,
  input  logic [5:0]       blink_idx,
  output logic [SEG_W-1:0] HEX
);

  // A zero hold would never expire, so it is promoted to one tick.
  localparam int HOLD_EFF = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
  localparam int CNT_W    = $clog2(HOLD_EFF + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_EFF);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [6:0]       SEG_LIMIT = 7'(SEG_W);

  typedef enum logic {GAME, MSG} state_t;

  state_t           state_q, state_d;
  logic [SEG_W-1:0] gframe_q, gframe_d;
  logic [SEG_W-1:0] mframe_q, mframe_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             blink_ph_q, blink_ph_d;
  logic [SEG_W-1:0] hex_q, hex_d;
  logic             seg_wr_ack_q, seg_wr_ack_d;
  logic             msg_ack_q, msg_ack_d;
  logic             msg_done_q, msg_done_d;
  logic             seg_idx_ok;
  logic             blink_idx_ok;

  assign seg_idx_ok   = ({1'b0, seg_wr_idx} < SEG_LIMIT);
  assign blink_idx_ok = ({1'b0, blink_idx} < SEG_LIMIT);

  // Arbitration and frame bookkeeping. In GAME the priority is clear, then
  // message, then segment write; a write is only taken when no ack is
  // currently showing, so a request still high during its ack cycle is not
  // mistaken for a second write.
  always_comb begin
    state_d      = state_q;
    gframe_d     = gframe_q;
    mframe_d     = mframe_q;
    hold_cnt_d   = hold_cnt_q;
    blink_ph_d   = blink_ph_q;
    seg_wr_ack_d = 1'b0;
    msg_ack_d    = 1'b0;
    msg_done_d   = 1'b0;

    case (state_q)
      GAME: begin
        if (tick) begin
          blink_ph_d = ~blink_ph_q;
        end
        if (clr_req) begin
          gframe_d = '1;
        end else if (msg_req) begin
          mframe_d   = msg_frame;
          hold_cnt_d = HOLD_LOAD;
          state_d    = MSG;
          msg_ack_d  = 1'b1;
        end else if (seg_wr_req && !seg_wr_ack_q) begin
          seg_wr_ack_d = 1'b1;
          // Out-of-range indices are acknowledged but leave the frame alone.
          if (seg_idx_ok) begin
            gframe_d[seg_wr_idx] = seg_wr_val;
          end
        end
      end
      MSG: begin
        // Clears still land on the game frame, invisible until exit.
        if (clr_req) begin
          gframe_d = '1;
        end
        if (tick) begin
          if (hold_cnt_q == CNT_ONE) begin
            gframe_d   = '1;
            state_d    = GAME;
            blink_ph_d = 1'b0;
            msg_done_d = 1'b1;
          end else begin
            hold_cnt_d = hold_cnt_q - CNT_ONE;
          end
        end
      end
      default: begin
        state_d = GAME;
      end
    endcase
  end

  // Display selection; the blink override beats whatever the game frame
  // holds for that segment, including a write in the same cycle.
  always_comb begin
    hex_d = gframe_q;
    if (state_q == MSG) begin
      hex_d = mframe_q;
    end else if (blink_en && blink_idx_ok) begin
      hex_d[blink_idx] = ~blink_ph_q;
    end
  end

  always_ff @(posedge clockInp) begin
    if (!resetN) begin
      state_q      <= GAME;
      gframe_q     <= '1;
      mframe_q     <= '1;
      hold_cnt_q   <= '0;
      blink_ph_q   <= 1'b0;
      hex_q        <= '1;
      seg_wr_ack_q <= 1'b0;
      msg_ack_q    <= 1'b0;
      msg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      gframe_q     <= gframe_d;
      mframe_q     <= mframe_d;
      hold_cnt_q   <= hold_cnt_d;
      blink_ph_q   <= blink_ph_d;
      hex_q        <= hex_d;
      seg_wr_ack_q <= seg_wr_ack_d;
      msg_ack_q    <= msg_ack_d;
      msg_done_q   <= msg_done_d;
    end
  end

  assign seg_wr_ack = seg_wr_ack_q;
  assign msg_ack    = msg_ack_q;
  assign msg_done   = msg_done_q;
  assign busy       = (state_q == MSG);
  assign HEX        = hex_q;

endmodule

// File: doc/hex_frame_arbiter.md
Name: hex_frame_arbiter

Overview:
- Owns the 48-bit HEX display bus (six active-low 7-seg+dp digits) and shares it between three requesters:
  - game engine: per-segment writes and frame clear;
  - message overlay: full-frame "COOL"/"U LOSE" style messages held for a number of move ticks;
  - apple blinker: a single segment toggled on each move tick.
- Sits between the snake game core and the board HEX pins.
- Replaces direct HEX manipulation inside the game core.

Parameters:
- SEG_W, 48, display width in segments (6 digits x 8).
- HOLD_TICKS, 20, move ticks a message stays on screen (0 treated as 1).

Ports:
- clockInp  in  1  system clock.
- resetN  in  1  synchronous active-low reset.
- tick  in  1  move tick, one clockInp cycle wide.
- seg_wr_req  in  1  game segment write request; held until ack.
- seg_wr_idx  in  6  segment index 0..47.
- seg_wr_val  in  1  segment value (0 = lit, 1 = dark).
- seg_wr_ack  out  1  one-cycle write acknowledge.
- clr_req  in  1  single-cycle pulse; clears the game frame to all dark.
- msg_req  in  1  message request; held until ack.
- msg_frame  in  48  message pattern, sampled on acceptance.
- msg_ack  out  1  one-cycle message acknowledge.
- msg_done  out  1  one-cycle pulse when the message hold expires.
- busy  out  1  high while a message owns the display.
- blink_en  in  1  apple blink enable.
- blink_idx  in  6  apple segment index.
- HEX  out  48  registered display output.

Behaviour:
Reset (resetN = 0 at a clockInp edge) forces:
- state = GAME, gframe = all 1s, mframe = all 1s, hold_cnt = 0, blink_ph = 0.
- HEX = 48'hFFFFFFFFFFFF.
- seg_wr_ack = msg_ack = msg_done = busy = 0.
- Reset mid-message aborts it with no msg_done.

States:
- GAME: display = gframe, with bit blink_idx replaced by ~blink_ph when blink_en = 1 and blink_idx < 48.
- MSG: display = mframe; blink is suppressed.
- HEX <= display every cycle, so HEX lags internal state by 1 cycle.

Per-cycle priority in GAME: clr_req > msg_req > seg_wr_req.
- clr_req: gframe <= all 1s. A pending seg write is not accepted this cycle.
- msg_req (and no clr_req):
  - mframe <= msg_frame; hold_cnt <= max(HOLD_TICKS, 1).
  - state <= MSG; msg_ack = 1 next cycle.
  - Simultaneous seg_wr_req is stalled.
- seg_wr_req: accepted only when seg_wr_ack is currently 0.
  - gframe[seg_wr_idx] <= seg_wr_val; seg_wr_ack = 1 next cycle.
  - Max one accepted write per 2 cycles. Requester drops req in the ack cycle; req still high in the ack cycle is not a new write.
  - seg_wr_idx >= 48: acked, frame unchanged.
- Write latency: req sampled at cycle N -> gframe updated at N+1 -> HEX shows it at N+2.

MSG state:
- seg_wr_req and msg_req are not acknowledged; requesters stall.
- clr_req still clears gframe; HEX is unaffected until exit.
- busy = 1 from the cycle after acceptance through the exit cycle.
- On tick: if hold_cnt == 1 then:
  - gframe <= all 1s, state <= GAME, blink_ph <= 0, msg_done = 1 next cycle;
  - else hold_cnt <= hold_cnt - 1.

blink_ph:
- Toggles on every tick while in GAME.
- Holds in MSG.
- blink_en = 0 -> bit shown straight from gframe.
- tick and a seg write to blink_idx in the same cycle: both take effect; the blink override still wins on HEX.

Test Plan:
1. Reset, then write idx 5 val 0 -> ack at N+1; HEX at N+2 = 48'hFFFFFFFFFFDF; next write accepted no earlier than N+2.
2. blink_en = 1, blink_idx = 0, 4 ticks -> HEX[0] sequence 0,1,0,1 (starts lit after the first tick); other bits unchanged.
3. HOLD_TICKS = 3, msg_req with msg_frame = 48'h123456789ABC ->
   - msg_ack at +1, HEX = msg_frame at +2, busy = 1;
   - the 3rd tick gives msg_done and HEX = all 1s; busy drops.
4. During MSG, seg_wr_req held 10 cycles -> no ack; ack 1 cycle after return to GAME; write lands on the cleared frame.
5. clr_req + msg_req + seg_wr_req in the same cycle -> gframe cleared, no msg_ack, no seg_wr_ack that cycle; msg accepted next cycle.
6. resetN low during MSG with hold_cnt = 5 -> next cycle state GAME, HEX all 1s, busy 0, no msg_done pulse.
